// File: rtl/vip_frame_sequencer_pkg.sv
// Shared definitions for the frame sequencer: state encoding and field widths.
package vip_pkg;

   // Geometry / frame-count field width and the pixel-count width derived from it.
   localparam int DIM_W = 11;
   localparam int PIX_W = 2 * DIM_W;

   // Default pixel width (RGB888).
   localparam int DWIDTH_DEF = 24;

   // Sequencer states; encoding is fixed so status taps stay stable.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/vip_frame_sequencer_if.sv
// Pixel-path bundle between the image source, the core input FIFO and the
// core output FIFO monitor taps. The slave side is the sequencer.
interface vip_frame_sequencer_if #(
   parameter int DWIDTH = 24
);
   logic [DWIDTH-1:0] src_data;
   logic              src_wrreq;
   logic              src_full;
   logic [DWIDTH-1:0] core_data;
   logic              core_wrreq;
   logic              core_full;
   logic              out_rdreq;
   logic              out_empty;

   // Environment side: source generator, core FIFO status and output taps.
   modport master (
      output src_data, src_wrreq, core_full, out_rdreq, out_empty,
      input  src_full, core_data, core_wrreq
   );

   // Sequencer side.
   modport slave (
      input  src_data, src_wrreq, core_full, out_rdreq, out_empty,
      output src_full, core_data, core_wrreq
   );
endinterface

// File: rtl/vip_frame_sequencer_xy_counter.sv
// Raster position counter: x runs 0..width-1, then wraps and advances y,
// which runs 0..height-1 and wraps back to 0 after the last pixel.
module vip_xy_counter
   import vip_pkg::*;
#(
   parameter int DIM_W = vip_pkg::DIM_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [DIM_W-1:0] width,
   input  logic [DIM_W-1:0] height,
   output logic [DIM_W-1:0] x,
   output logic [DIM_W-1:0] y,
   output logic             last_x,
   output logic             last_xy
);

   localparam logic [DIM_W-1:0] ONE = 1;

   logic [DIM_W-1:0] x_reg, x_next;
   logic [DIM_W-1:0] y_reg, y_next;

   assign x       = x_reg;
   assign y       = y_reg;
   assign last_x  = (x_reg == width - ONE);
   assign last_xy = last_x && (y_reg == height - ONE);

   // Next position: clear wins, otherwise step along the raster on en.
   always_comb begin
      x_next = x_reg;
      y_next = y_reg;
      if (clr) begin
         x_next = '0;
         y_next = '0;
      end else if (en) begin
         if (last_x) begin
            x_next = '0;
            y_next = last_xy ? '0 : (y_reg + ONE);
         end else begin
            x_next = x_reg + ONE;
         end
      end
   end

   // Position registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         x_reg <= '0;
         y_reg <= '0;
      end else begin
         x_reg <= x_next;
         y_reg <= y_next;
      end
   end

endmodule

// File: rtl/vip_frame_sequencer.sv
// Frame-level sequencer in front of the video core. Admits exactly
// width*height pixels per frame into the core input FIFO, then waits until the
// same number of pixels has been read from the core output FIFO before opening
// the next frame, so at most one frame is ever inside the core.
module vip_frame_sequencer
   import vip_pkg::*;
#(
   parameter int DWIDTH = vip_pkg::DWIDTH_DEF,
   parameter int DIM_W  = vip_pkg::DIM_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIM_W-1:0]      cfg_width,
   input  logic [DIM_W-1:0]      cfg_height,
   input  logic [DIM_W-1:0]      cfg_num_frame,
   vip_frame_sequencer_if.slave  bus,
   output logic                  sof,
   output logic                  eol,
   output logic                  eof,
   output logic [DIM_W-1:0]      frame_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  err_overrun
);

   localparam int               CNT_W    = 2 * DIM_W;
   localparam logic [DIM_W:0]   IDX_ONE  = 1;
   localparam logic [DIM_W-1:0] FIDX_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;

   seq_state_t       state_reg, state_next;
   logic [DIM_W-1:0] width_reg, width_next;
   logic [DIM_W-1:0] height_reg, height_next;
   logic [DIM_W-1:0] num_reg, num_next;
   logic [DIM_W-1:0] frame_idx_reg, frame_idx_next;
   logic [CNT_W-1:0] total_reg, total_next;
   logic [CNT_W-1:0] out_cnt_reg, out_cnt_next;
   logic [CNT_W-1:0] cnt_sum;
   logic             err_reg, err_next;
   logic             sof_reg, eol_reg, eof_reg;

   logic [DWIDTH-1:0] pix;
   logic              run_st;
   logic              counting;
   logic              in_acc;
   logic              out_acc;
   logic              start_ok;
   logic              frame_complete;
   logic              more_frames;
   logic              advance;

   logic [DIM_W-1:0]  x, y;
   logic              last_x, last_xy;

   logic [DIM_W-1:0]  cfg_arr [3];
   logic [2:0]        cfg_nz;

   // A start is only meaningful if every config field is non-zero.
   assign cfg_arr[0] = cfg_width;
   assign cfg_arr[1] = cfg_height;
   assign cfg_arr[2] = cfg_num_frame;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_cfg_nz
         assign cfg_nz[gi] = |cfg_arr[gi];
      end
   endgenerate

   assign run_st   = (state_reg == ST_RUN);
   assign counting = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
   assign in_acc   = bus.src_wrreq && !bus.core_full && run_st;
   assign out_acc  = bus.out_rdreq && !bus.out_empty;
   assign start_ok = start && &cfg_nz &&
                     ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

   // Zero-latency input path: the sequencer only gates the write strobe.
   assign pix            = bus.src_data;
   assign bus.core_data  = pix;
   assign bus.core_wrreq = in_acc;
   assign bus.src_full   = bus.core_full || !run_st;

   // Output count including this cycle's beat, so the last read completes
   // the frame in the same cycle it happens, whatever state we are in.
   assign cnt_sum        = out_cnt_reg + ((counting && out_acc) ? CNT_ONE : '0);
   assign frame_complete = counting && (cnt_sum == total_reg);
   assign more_frames    = ({1'b0, frame_idx_reg} + IDX_ONE) < {1'b0, num_reg};

   // Frame hand-over happens either from DRAIN, or straight from RUN when the
   // last input beat and the last output beat coincide.
   assign advance = frame_complete &&
                    ((run_st && in_acc && last_xy) || (state_reg == ST_DRAIN));

   vip_xy_counter #(
      .DIM_W (DIM_W)
   ) u_xy (
      .clock   (clock),
      .reset   (reset),
      .clr     (start_ok),
      .en      (in_acc),
      .width   (width_reg),
      .height  (height_reg),
      .x       (x),
      .y       (y),
      .last_x  (last_x),
      .last_xy (last_xy)
   );

   // Next-state logic for the FSM, config latch, frame and output counters.
   always_comb begin
      state_next     = state_reg;
      width_next     = width_reg;
      height_next    = height_reg;
      num_next       = num_reg;
      total_next     = total_reg;
      out_cnt_next   = out_cnt_reg;
      frame_idx_next = frame_idx_reg;
      err_next       = err_reg;

      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start_ok) begin
               width_next     = cfg_width;
               height_next    = cfg_height;
               num_next       = cfg_num_frame;
               total_next     = CNT_W'(cfg_width) * CNT_W'(cfg_height);
               out_cnt_next   = '0;
               frame_idx_next = '0;
               err_next       = 1'b0;
               state_next     = ST_RUN;
            end else if (out_acc) begin
               // Output with no frame outstanding: flag it, do not count it.
               err_next = 1'b1;
            end
         end
         ST_RUN: begin
            out_cnt_next = cnt_sum;
            if (in_acc && last_xy) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            out_cnt_next = cnt_sum;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (advance) begin
         out_cnt_next = '0;
         if (more_frames) begin
            frame_idx_next = frame_idx_reg + FIDX_ONE;
            state_next     = ST_RUN;
         end else begin
            state_next = ST_DONE;
         end
      end
   end

   // State, config and counter registers plus the one-cycle raster markers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         width_reg     <= '0;
         height_reg    <= '0;
         num_reg       <= '0;
         total_reg     <= '0;
         out_cnt_reg   <= '0;
         frame_idx_reg <= '0;
         err_reg       <= 1'b0;
         sof_reg       <= 1'b0;
         eol_reg       <= 1'b0;
         eof_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         width_reg     <= width_next;
         height_reg    <= height_next;
         num_reg       <= num_next;
         total_reg     <= total_next;
         out_cnt_reg   <= out_cnt_next;
         frame_idx_reg <= frame_idx_next;
         err_reg       <= err_next;
         sof_reg       <= in_acc && (x == '0) && (y == '0);
         eol_reg       <= in_acc && last_x;
         eof_reg       <= in_acc && last_xy;
      end
   end

   assign sof         = sof_reg;
   assign eol         = eol_reg;
   assign eof         = eof_reg;
   assign frame_idx   = frame_idx_reg;
   assign busy        = counting;
   assign done        = (state_reg == ST_DONE);
   assign err_overrun = err_reg;

endmodule
